// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: boot hold, load-use bubbles, multi-cycle EX freeze, branch squash, error drain/halt.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef REG_BUS
`define REG_BUS 4:0
`endif
`ifndef REG_X0
`define REG_X0 5'h0
`endif

module pipe_ctrl #(
  parameter int BOOT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_error_i,
  input  logic [`DATA_BUS] id_pc_i,
  input  logic [`REG_BUS]  id_rs1_i,
  input  logic [`REG_BUS]  id_rs2_i,
  input  logic            ex_is_load_i,
  input  logic [`REG_BUS]  ex_gprs_waddr_i,
  input  logic            ex_busy_i,
  input  logic            branch_taken_i,
  output logic            if_stall_o,
  output logic            id_stall_o,
  output logic            ex_stall_o,
  output logic            if_flush_o,
  output logic            id_flush_o,
  output logic            halted_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]     perf_cycles_o,
  output logic [31:0]     perf_stalls_o,
  output logic [31:0]     perf_flushes_o,
`endif
  output logic [`DATA_BUS] error_pc_o
);

  generate
    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15) begin : g_bad_boot
      $error("pipe_ctrl: BOOT_CYCLES must be in 1..15");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
      $error("pipe_ctrl: DRAIN_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_t;

  state_t     state, nstate;
  logic [3:0] cnt, ncnt;
  logic       err_cap;
  logic       hazard;

  // Forwarding covers everything except a load still in EX; x0 never creates a dependency.
  assign hazard = ex_is_load_i && (ex_gprs_waddr_i != `REG_X0) &&
                  ((id_rs1_i == ex_gprs_waddr_i) || (id_rs2_i == ex_gprs_waddr_i));

  always_comb begin
    nstate     = state;
    ncnt       = cnt;
    err_cap    = 1'b0;
    if_stall_o = 1'b0;
    id_stall_o = 1'b0;
    ex_stall_o = 1'b0;
    if_flush_o = 1'b0;
    id_flush_o = 1'b0;
    case (state)
      BOOT: begin
        {if_stall_o, id_stall_o, ex_stall_o, if_flush_o, id_flush_o} = 5'b11111;
        if (cnt == BOOT_LAST) begin
          nstate = RUN;
          ncnt   = 4'd0;
        end else begin
          ncnt = cnt + 4'd1;
        end
      end
      RUN: begin
        if (ex_busy_i) begin
          {if_stall_o, id_stall_o, ex_stall_o} = 3'b111;
        end else if (branch_taken_i) begin
          // Anything younger than the branch is wrong-path, errors included.
          {if_flush_o, id_flush_o} = 2'b11;
        end else if (hazard) begin
          {if_stall_o, id_stall_o, id_flush_o} = 3'b111;
        end else if (id_error_i) begin
          if_stall_o = 1'b1;
          id_flush_o = 1'b1;
          err_cap    = 1'b1;
          nstate     = DRAIN;
          ncnt       = 4'd0;
        end
      end
      DRAIN: begin
        {if_stall_o, id_stall_o, id_flush_o} = 3'b111;
        ex_stall_o = ex_busy_i;
        // Drain time only advances while EX is actually retiring.
        if (!ex_busy_i) begin
          if (cnt == DRAIN_LAST) nstate = HALT;
          else                   ncnt   = cnt + 4'd1;
        end
      end
      default: begin
        {if_stall_o, id_stall_o, ex_stall_o, if_flush_o, id_flush_o} = 5'b11111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      cnt        <= 4'd0;
      halted_o   <= 1'b0;
      error_pc_o <= '0;
    end else begin
      state    <= nstate;
      cnt      <= ncnt;
      halted_o <= halted_o | (nstate == HALT);
      if (err_cap) error_pc_o <= id_pc_i;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_o  <= '0;
      perf_stalls_o  <= '0;
      perf_flushes_o <= '0;
    end else if (state == RUN) begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
      if (if_stall_o) perf_stalls_o  <= perf_stalls_o + 32'd1;
      if (if_flush_o) perf_flushes_o <= perf_flushes_o + 32'd1;
    end
  end
`endif

endmodule
